timer_countdown: RTL and testbench
==================================

// Module: timer_countdown
// PURPOSE
//  Microwave cook-time register and mm:ss BCD down-counter, directly downstream of timer_controler.
//  Shifts keypad digits in on each loadn strobe and counts down once per pgt_1Hz tick while running.
//  Reports running/done to the magnetron and alarm logic, and the four digits to the display drivers.
// PARAMETERS
//  SEC_TENS_WRAP  5  value loaded into secs_tens on a minute borrow (00 -> 59)
//  DIGIT_MAX      9  largest legal BCD digit; larger bcd values are discarded
// PORTS
//  clk_100Hz   in   1  system clock; all state changes on its rising edge
//  clear       in   1  asynchronous, active-high reset
//  bcd         in   4  digit from timer_controler, bcd[0] = MSB
//  loadn       in   1  active-low digit strobe from timer_controler, one clock per key
//  pgt_1Hz     in   1  one-clock 1 Hz tick from timer_controler
//  startn      in   1  active-low start request (level-sampled each clock)
//  stopn       in   1  active-low stop/cancel request (level-sampled each clock)
//  door_closed in   1  1 = door closed, interlock for running
//  mins_tens   out  4  BCD minutes tens
//  mins_units  out  4  BCD minutes units
//  secs_tens   out  4  BCD seconds tens
//  secs_units  out  4  BCD seconds units
//  zero        out  1  combinational: all four digits == 0
//  running     out  1  registered: state == RUN
//  done        out  1  registered: state == DONE (alarm request)
// BEHAVIOUR
//  Reset (clear=1, asynchronous): all digits 0, state IDLE, running=0, done=0; zero therefore reads 1.
//  States: IDLE, RUN, PAUSE, DONE. Per-clock priority: clear > stopn > door_closed=0 > startn > pgt_1Hz > loadn.
//  Digit shift (IDLE, or DONE), loadn=0 and bcd<=DIGIT_MAX:
//   mins_tens<=mins_units, mins_units<=secs_tens, secs_tens<=secs_units, secs_units<=bcd.
//   The shift takes effect in the same clock (no latency).
//   In DONE, the first such strobe first clears all digits, then shifts, and the state goes to IDLE.
//   bcd>DIGIT_MAX is ignored. loadn in RUN or PAUSE is ignored.
//  Transitions:
//   IDLE -> RUN: startn=0, door_closed=1 and zero=0. startn with zero=1 or with the door open is ignored.
//   IDLE, stopn=0: digits cleared, stays IDLE.
//   RUN -> PAUSE: stopn=0 or door_closed=0. Digits hold. A pgt_1Hz in the same clock is dropped.
//   RUN, pgt_1Hz=1: decrement the time by one second (see Decrement).
//    If the pre-tick value is 00:01, the digits become 00:00 and the state goes to DONE on the same edge.
//   PAUSE -> RUN: startn=0 and door_closed=1.
//   PAUSE -> IDLE: stopn=0, digits cleared.
//   DONE -> IDLE: stopn=0, digits cleared.
//   DONE: done stays 1 until left; startn and pgt_1Hz are ignored.
//  Decrement (BCD, borrow chain):
//   secs_units 0 -> 9 with borrow, else -1.
//   secs_tens on borrow: 0 -> SEC_TENS_WRAP with borrow to minutes, else -1.
//   mins_units 0 -> 9 with borrow, else -1. mins_tens decrements on borrow.
//   Entered seconds above 59 (e.g. 01:90) are legal: 01:90 -> 01:89 ... 01:00 -> 00:59.
//   99:99 is the maximum. 00:00 is never decremented (it is only reachable in IDLE or DONE).
//  Outputs never take non-BCD values.
// STRUCTURE
//  Shared package timer_pkg:
//   state localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2, ST_DONE=2'd3;
//   BCD_ZERO=4'd0, BCD_NINE=4'd9.
//  Sub-module bcd_digit_down (params WRAP):
//   ports clk_100Hz, clear, load_en, load_val, dec_en;
//   outputs q[3:0] and borrow_out (dec_en && q==0).
//  Four instances, chained by borrow, plus the FSM and shift mux in timer_countdown.
// TESTING
//  1 Entry: clear, then loadn strobes with bcd 1,2,3,0 -> digits 12:30, zero=0, state IDLE.
//  2 Countdown: load 00:02, startn=0 1 clk, two pgt_1Hz ticks -> 00:01, then 00:00.
//    done=1 and running=0 on the second tick's edge; stopn -> IDLE, done=0.
//  3 Borrow: load 10:00, run, one tick -> 09:59. Load 01:90, one tick -> 01:89.
//  4 Interlock: run 05:00, door_closed=0 together with pgt_1Hz -> PAUSE, digits stay 05:00.
//    startn while door open -> no change. Door closed + startn -> RUN.
//  5 Rejects: bcd=4'd12 with loadn=0 -> digits unchanged. loadn during RUN -> unchanged.
//    startn at 00:00 -> stays IDLE.
//  6 Async reset: assert clear between clock edges mid-RUN at 03:17 -> immediately 00:00, IDLE, running=0.

Source files
------------

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_pkg
// Purpose  : Shared state encodings and BCD constants for the microwave
//            cook-time countdown (timer_countdown and its digit cells).
// Contents : ST_IDLE/ST_RUN/ST_PAUSE/ST_DONE state codes, BCD_ZERO, BCD_NINE
// Revision : 1.0  initial release
// ============================================================================
package timer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] BCD_ZERO = 4'd0;
    localparam logic [3:0] BCD_NINE = 4'd9;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/timer_countdown_if.sv
`default_nettype none
// ============================================================================
// Module   : timer_countdown_if
// Purpose  : Bundles the keypad/controller inputs and the display/status
//            outputs of timer_countdown.
// Ports    : bcd[0:3] (bcd[0] = MSB), loadn, pgt_1Hz, startn, stopn,
//            door_closed  -> countdown
//            mins_tens, mins_units, secs_tens, secs_units, zero, running,
//            done         <- countdown
//            master = controller/environment side, slave = countdown side
// Revision : 1.0  initial release
// ============================================================================
interface timer_countdown_if;

    // Declared [0:3] so that bit 0 is the most significant bit numerically.
    logic [0:3] bcd;
    logic       loadn;
    logic       pgt_1Hz;
    logic       startn;
    logic       stopn;
    logic       door_closed;

    logic [3:0] mins_tens;
    logic [3:0] mins_units;
    logic [3:0] secs_tens;
    logic [3:0] secs_units;
    logic       zero;
    logic       running;
    logic       done;

    modport master (
        output bcd, loadn, pgt_1Hz, startn, stopn, door_closed,
        input  mins_tens, mins_units, secs_tens, secs_units, zero, running, done
    );

    modport slave (
        input  bcd, loadn, pgt_1Hz, startn, stopn, door_closed,
        output mins_tens, mins_units, secs_tens, secs_units, zero, running, done
    );

endinterface : timer_countdown_if
`default_nettype wire

// File: rtl/bcd_digit_down.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_down
// Purpose  : One loadable BCD down-counting digit with borrow output.
// Ports    : clk_100Hz  in  clock
//            clear      in  asynchronous active-high reset (digit -> 0)
//            load_en    in  load load_val (takes priority over dec_en)
//            load_val   in  value to load
//            dec_en     in  decrement by one (0 wraps to WRAP)
//            q          out current digit
//            borrow_out out dec_en while the digit is 0 (wrap to next digit)
// Params   : WRAP  value taken when decrementing from 0
// Revision : 1.0  initial release
// ============================================================================
module bcd_digit_down
    import timer_pkg::*;
#(
    parameter logic [3:0] WRAP = BCD_NINE
) (
    input  wire logic       clk_100Hz,
    input  wire logic       clear,
    input  wire logic       load_en,
    input  wire logic [3:0] load_val,
    input  wire logic       dec_en,
    output logic      [3:0] q,
    output logic            borrow_out
);

    logic [3:0] r_q;

    always_ff @(posedge clk_100Hz or posedge clear) begin
        if (clear) begin
            r_q <= BCD_ZERO;
        end else if (load_en) begin
            r_q <= load_val;
        end else if (dec_en) begin
            r_q <= (r_q == BCD_ZERO) ? WRAP : (r_q - 4'd1);
        end
    end

    assign q          = r_q;
    assign borrow_out = dec_en && (r_q == BCD_ZERO);

endmodule : bcd_digit_down
`default_nettype wire

// File: rtl/timer_countdown.sv
`default_nettype none
// ============================================================================
// Module   : timer_countdown
// Purpose  : Microwave cook-time register and mm:ss BCD down-counter.
//            Keypad digits shift in on loadn strobes; while running the time
//            counts down once per pgt_1Hz tick and raises done at 00:00.
// Ports    : clk_100Hz in  system clock
//            clear     in  asynchronous active-high reset
//            bus       slave modport of timer_countdown_if (keypad strobes,
//                      start/stop, door interlock, 1 Hz tick in; four BCD
//                      digits, zero, running, done out)
// Params   : SEC_TENS_WRAP  secs_tens value after a minute borrow (00 -> 59)
//            DIGIT_MAX      largest accepted keypad digit
// Revision : 1.0  initial release
// ============================================================================
module timer_countdown
    import timer_pkg::*;
#(
    parameter logic [3:0] SEC_TENS_WRAP = 4'd5,
    parameter logic [3:0] DIGIT_MAX     = BCD_NINE
) (
    input  wire logic        clk_100Hz,
    input  wire logic        clear,
    timer_countdown_if.slave bus
);

    logic [1:0] r_state;
    logic       r_running;
    logic       r_done;

    logic [1:0] w_next_state;
    logic       w_clr;        // load all-zero digits
    logic       w_shift;      // shift a keypad digit in
    logic       w_pre_clear;  // shift into an already-cleared register
    logic       w_dec;        // decrement by one second

    logic [3:0] w_bcd;
    logic [3:0] w_mt, w_mu, w_st, w_su;
    logic [3:0] w_ld_mt, w_ld_mu, w_ld_st, w_ld_su;
    logic       w_load_en;
    logic       w_borrow_su, w_borrow_st, w_borrow_mu, w_borrow_mt;
    logic       w_key_valid;
    logic       w_stop, w_start, w_door_open, w_tick;
    logic       w_zero, w_one;

    // Numeric copy; bus.bcd is declared MSB-at-index-0.
    assign w_bcd       = bus.bcd;
    assign w_key_valid = !bus.loadn && (w_bcd <= DIGIT_MAX);
    assign w_stop      = !bus.stopn;
    assign w_start     = !bus.startn;
    assign w_door_open = !bus.door_closed;
    assign w_tick      = bus.pgt_1Hz;

    assign w_zero = ({w_mt, w_mu, w_st, w_su} == 16'h0000);
    assign w_one  = ({w_mt, w_mu, w_st, w_su} == 16'h0001);

    // Next-state and datapath control, honouring
    // stop > door open > start > tick > key within each state.
    always_comb begin
        w_next_state = r_state;
        w_clr        = 1'b0;
        w_shift      = 1'b0;
        w_pre_clear  = 1'b0;
        w_dec        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_stop) begin
                    w_clr = 1'b1;
                end else if (w_start && !w_door_open && !w_zero) begin
                    w_next_state = ST_RUN;
                end else if (w_key_valid) begin
                    w_shift = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_stop || w_door_open) begin
                    // Pause wins over a coincident tick; that tick is lost.
                    w_next_state = ST_PAUSE;
                end else if (w_tick) begin
                    w_dec = 1'b1;
                    // w_borrow_mt can only assert on an underflow of 00:00,
                    // which is never decremented; it is a defensive stop.
                    if (w_one || w_borrow_mt) begin
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_PAUSE: begin
                if (w_stop) begin
                    w_clr        = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (w_start && !w_door_open) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DONE: begin
                if (w_stop) begin
                    w_clr        = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (w_key_valid) begin
                    // First key after completion starts a fresh entry.
                    w_shift      = 1'b1;
                    w_pre_clear  = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_load_en = w_clr || w_shift;
    assign w_ld_mt   = (w_clr || w_pre_clear) ? BCD_ZERO : w_mu;
    assign w_ld_mu   = (w_clr || w_pre_clear) ? BCD_ZERO : w_st;
    assign w_ld_st   = (w_clr || w_pre_clear) ? BCD_ZERO : w_su;
    assign w_ld_su   = w_clr ? BCD_ZERO : w_bcd;

    // Digit chain: each borrow enables the next-more-significant digit.
    bcd_digit_down #(.WRAP(BCD_NINE)) u_secs_units (
        .clk_100Hz  (clk_100Hz),
        .clear      (clear),
        .load_en    (w_load_en),
        .load_val   (w_ld_su),
        .dec_en     (w_dec),
        .q          (w_su),
        .borrow_out (w_borrow_su)
    );

    bcd_digit_down #(.WRAP(SEC_TENS_WRAP)) u_secs_tens (
        .clk_100Hz  (clk_100Hz),
        .clear      (clear),
        .load_en    (w_load_en),
        .load_val   (w_ld_st),
        .dec_en     (w_borrow_su),
        .q          (w_st),
        .borrow_out (w_borrow_st)
    );

    bcd_digit_down #(.WRAP(BCD_NINE)) u_mins_units (
        .clk_100Hz  (clk_100Hz),
        .clear      (clear),
        .load_en    (w_load_en),
        .load_val   (w_ld_mu),
        .dec_en     (w_borrow_st),
        .q          (w_mu),
        .borrow_out (w_borrow_mu)
    );

    bcd_digit_down #(.WRAP(BCD_NINE)) u_mins_tens (
        .clk_100Hz  (clk_100Hz),
        .clear      (clear),
        .load_en    (w_load_en),
        .load_val   (w_ld_mt),
        .dec_en     (w_borrow_mu),
        .q          (w_mt),
        .borrow_out (w_borrow_mt)
    );

    // State register with status outputs registered from the next state so
    // they change on the same edge as the state itself.
    always_ff @(posedge clk_100Hz or posedge clear) begin
        if (clear) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_running <= (w_next_state == ST_RUN);
            r_done    <= (w_next_state == ST_DONE);
        end
    end

    assign bus.mins_tens  = w_mt;
    assign bus.mins_units = w_mu;
    assign bus.secs_tens  = w_st;
    assign bus.secs_units = w_su;
    assign bus.zero       = w_zero;
    assign bus.running    = r_running;
    assign bus.done       = r_done;

endmodule : timer_countdown
`default_nettype wire

// File: tb/tb_timer_countdown.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_countdown
// Purpose  : Self-checking bench for timer_countdown. Each step pushes the
//            expected {digits, running, done, zero} to a scoreboard queue and
//            captures the DUT response; each scenario task compares them.
// Revision : 1.0  initial release
// ============================================================================
module tb_timer_countdown;

    logic clk_100Hz = 1'b0;
    logic clear;

    timer_countdown_if bus ();

    timer_countdown #(
        .SEC_TENS_WRAP (4'd5),
        .DIGIT_MAX     (4'd9)
    ) dut (
        .clk_100Hz (clk_100Hz),
        .clear     (clear),
        .bus       (bus)
    );

    always #5 clk_100Hz = ~clk_100Hz;

    typedef struct {
        string       name;
        logic [18:0] v;     // {mm:ss digits, running, done, zero}
    } exp_t;

    exp_t        sb[$];
    logic [18:0] act[$];
    int          checks   = 0;
    int          failures = 0;

    function automatic logic [18:0] obs();
        return {bus.mins_tens, bus.mins_units, bus.secs_tens, bus.secs_units,
                bus.running, bus.done, bus.zero};
    endfunction

    function automatic logic [18:0] mk(logic [15:0] d, logic r, logic dn);
        return {d, r, dn, (d == 16'h0000)};
    endfunction

    task automatic idle_in();
        bus.bcd         = 4'd0;
        bus.loadn       = 1'b1;
        bus.pgt_1Hz     = 1'b0;
        bus.startn      = 1'b1;
        bus.stopn       = 1'b1;
        bus.door_closed = 1'b1;
    endtask

    task automatic cyc();
        @(posedge clk_100Hz);
        #1;
    endtask

    // One clock with the currently driven inputs; record expected and actual.
    task automatic step(string n, logic [15:0] d, logic r, logic dn);
        sb.push_back('{n, mk(d, r, dn)});
        cyc();
        act.push_back(obs());
    endtask

    task automatic key(string n, logic [3:0] v, logic [15:0] d, logic r);
        bus.bcd   = v;
        bus.loadn = 1'b0;
        step(n, d, r, 1'b0);
        bus.loadn = 1'b1;
    endtask

    task automatic press_stop(string n, logic [15:0] d);
        bus.stopn = 1'b0;
        step(n, d, 1'b0, 1'b0);
        bus.stopn = 1'b1;
    endtask

    task automatic press_start(string n, logic [15:0] d, logic r);
        bus.startn = 1'b0;
        step(n, d, r, 1'b0);
        bus.startn = 1'b1;
    endtask

    task automatic test_reset();
        exp_t        e;
        logic [18:0] a;
        idle_in();
        clear = 1'b1;
        #12;
        sb.push_back('{"reset_state", mk(16'h0000, 1'b0, 1'b0)});
        act.push_back(obs());
        clear = 1'b0;
        cyc();
        step("reset_hold", 16'h0000, 1'b0, 1'b0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (act.size() == 0) begin
                failures++;
                $display("FAIL %s: no DUT output captured", e.name);
            end else begin
                a = act.pop_front();
                if (a !== e.v) begin
                    failures++;
                    $display("FAIL %s: got mmss=%h run=%b done=%b zero=%b, required mmss=%h run=%b done=%b zero=%b",
                             e.name, a[18:3], a[2], a[1], a[0], e.v[18:3], e.v[2], e.v[1], e.v[0]);
                end
            end
        end
    endtask

    task automatic test_entry();
        exp_t        e;
        logic [18:0] a;
        key("entry_1", 4'd1, 16'h0001, 1'b0);
        key("entry_2", 4'd2, 16'h0012, 1'b0);
        key("entry_3", 4'd3, 16'h0123, 1'b0);
        key("entry_0", 4'd0, 16'h1230, 1'b0);
        press_stop("entry_stop_clears", 16'h0000);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (act.size() == 0) begin
                failures++;
                $display("FAIL %s: no DUT output captured", e.name);
            end else begin
                a = act.pop_front();
                if (a !== e.v) begin
                    failures++;
                    $display("FAIL %s: got mmss=%h run=%b done=%b zero=%b, required mmss=%h run=%b done=%b zero=%b",
                             e.name, a[18:3], a[2], a[1], a[0], e.v[18:3], e.v[2], e.v[1], e.v[0]);
                end
            end
        end
    endtask

    task automatic test_countdown();
        exp_t        e;
        logic [18:0] a;
        key("cd_key0", 4'd0, 16'h0000, 1'b0);
        key("cd_key2", 4'd2, 16'h0002, 1'b0);
        press_start("cd_start", 16'h0002, 1'b1);
        bus.pgt_1Hz = 1'b1;
        step("cd_tick1", 16'h0001, 1'b1, 1'b0);
        step("cd_tick2_done", 16'h0000, 1'b0, 1'b1);
        step("cd_done_tick_ignored", 16'h0000, 1'b0, 1'b1);
        bus.pgt_1Hz = 1'b0;
        bus.startn  = 1'b0;
        step("cd_done_start_ignored", 16'h0000, 1'b0, 1'b1);
        bus.startn  = 1'b1;
        press_stop("cd_stop_idle", 16'h0000);
        // Done followed directly by a key: fresh entry, back to IDLE.
        key("cd_reload_key1", 4'd1, 16'h0001, 1'b0);
        press_start("cd_reload_start", 16'h0001, 1'b1);
        bus.pgt_1Hz = 1'b1;
        step("cd_reload_done", 16'h0000, 1'b0, 1'b1);
        bus.pgt_1Hz = 1'b0;
        key("cd_done_key5", 4'd5, 16'h0005, 1'b0);
        press_stop("cd_reload_clear", 16'h0000);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (act.size() == 0) begin
                failures++;
                $display("FAIL %s: no DUT output captured", e.name);
            end else begin
                a = act.pop_front();
                if (a !== e.v) begin
                    failures++;
                    $display("FAIL %s: got mmss=%h run=%b done=%b zero=%b, required mmss=%h run=%b done=%b zero=%b",
                             e.name, a[18:3], a[2], a[1], a[0], e.v[18:3], e.v[2], e.v[1], e.v[0]);
                end
            end
        end
    endtask

    task automatic test_borrow();
        exp_t        e;
        logic [18:0] a;
        key("br_k1", 4'd1, 16'h0001, 1'b0);
        key("br_k0a", 4'd0, 16'h0010, 1'b0);
        key("br_k0b", 4'd0, 16'h0100, 1'b0);
        key("br_k0c", 4'd0, 16'h1000, 1'b0);
        press_start("br_start", 16'h1000, 1'b1);
        bus.pgt_1Hz = 1'b1;
        step("br_1000_to_0959", 16'h0959, 1'b1, 1'b0);
        bus.pgt_1Hz = 1'b0;
        press_stop("br_pause_holds", 16'h0959);
        press_stop("br_pause_stop_clears", 16'h0000);
        key("br_k0", 4'd0, 16'h0000, 1'b0);
        key("br_k1b", 4'd1, 16'h0001, 1'b0);
        key("br_k9", 4'd9, 16'h0019, 1'b0);
        key("br_k0d", 4'd0, 16'h0190, 1'b0);
        press_start("br_start_0190", 16'h0190, 1'b1);
        bus.pgt_1Hz = 1'b1;
        step("br_0190_to_0189", 16'h0189, 1'b1, 1'b0);
        bus.pgt_1Hz = 1'b0;
        press_stop("br_pause2", 16'h0189);
        press_stop("br_clear2", 16'h0000);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (act.size() == 0) begin
                failures++;
                $display("FAIL %s: no DUT output captured", e.name);
            end else begin
                a = act.pop_front();
                if (a !== e.v) begin
                    failures++;
                    $display("FAIL %s: got mmss=%h run=%b done=%b zero=%b, required mmss=%h run=%b done=%b zero=%b",
                             e.name, a[18:3], a[2], a[1], a[0], e.v[18:3], e.v[2], e.v[1], e.v[0]);
                end
            end
        end
    endtask

    task automatic test_interlock();
        exp_t        e;
        logic [18:0] a;
        key("il_k0", 4'd0, 16'h0000, 1'b0);
        key("il_k5", 4'd5, 16'h0005, 1'b0);
        key("il_k0b", 4'd0, 16'h0050, 1'b0);
        key("il_k0c", 4'd0, 16'h0500, 1'b0);
        press_start("il_start", 16'h0500, 1'b1);
        bus.door_closed = 1'b0;
        bus.pgt_1Hz     = 1'b1;
        step("il_door_open_drops_tick", 16'h0500, 1'b0, 1'b0);
        bus.pgt_1Hz     = 1'b0;
        press_start("il_start_door_open", 16'h0500, 1'b0);
        bus.door_closed = 1'b1;
        press_start("il_resume", 16'h0500, 1'b1);
        bus.pgt_1Hz     = 1'b1;
        step("il_tick_after_resume", 16'h0459, 1'b1, 1'b0);
        bus.pgt_1Hz     = 1'b0;
        press_stop("il_pause", 16'h0459);
        press_stop("il_clear", 16'h0000);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (act.size() == 0) begin
                failures++;
                $display("FAIL %s: no DUT output captured", e.name);
            end else begin
                a = act.pop_front();
                if (a !== e.v) begin
                    failures++;
                    $display("FAIL %s: got mmss=%h run=%b done=%b zero=%b, required mmss=%h run=%b done=%b zero=%b",
                             e.name, a[18:3], a[2], a[1], a[0], e.v[18:3], e.v[2], e.v[1], e.v[0]);
                end
            end
        end
    endtask

    task automatic test_rejects();
        exp_t        e;
        logic [18:0] a;
        key("rj_k3", 4'd3, 16'h0003, 1'b0);
        key("rj_k4", 4'd4, 16'h0034, 1'b0);
        key("rj_bcd12", 4'd12, 16'h0034, 1'b0);
        key("rj_bcd10", 4'd10, 16'h0034, 1'b0);
        press_start("rj_start", 16'h0034, 1'b1);
        key("rj_key_in_run", 4'd7, 16'h0034, 1'b1);
        press_stop("rj_pause", 16'h0034);
        key("rj_key_in_pause", 4'd7, 16'h0034, 1'b0);
        press_stop("rj_clear", 16'h0000);
        press_start("rj_start_at_zero", 16'h0000, 1'b0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (act.size() == 0) begin
                failures++;
                $display("FAIL %s: no DUT output captured", e.name);
            end else begin
                a = act.pop_front();
                if (a !== e.v) begin
                    failures++;
                    $display("FAIL %s: got mmss=%h run=%b done=%b zero=%b, required mmss=%h run=%b done=%b zero=%b",
                             e.name, a[18:3], a[2], a[1], a[0], e.v[18:3], e.v[2], e.v[1], e.v[0]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t        e;
        logic [18:0] a;
        key("ar_k0", 4'd0, 16'h0000, 1'b0);
        key("ar_k3", 4'd3, 16'h0003, 1'b0);
        key("ar_k1", 4'd1, 16'h0031, 1'b0);
        key("ar_k7", 4'd7, 16'h0317, 1'b0);
        press_start("ar_start", 16'h0317, 1'b1);
        // Mid-cycle, well away from the next rising edge.
        #2;
        clear = 1'b1;
        #1;
        sb.push_back('{"ar_immediate_clear", mk(16'h0000, 1'b0, 1'b0)});
        act.push_back(obs());
        #2;
        clear = 1'b0;
        bus.pgt_1Hz = 1'b1;
        step("ar_idle_after_clear", 16'h0000, 1'b0, 1'b0);
        bus.pgt_1Hz = 1'b0;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (act.size() == 0) begin
                failures++;
                $display("FAIL %s: no DUT output captured", e.name);
            end else begin
                a = act.pop_front();
                if (a !== e.v) begin
                    failures++;
                    $display("FAIL %s: got mmss=%h run=%b done=%b zero=%b, required mmss=%h run=%b done=%b zero=%b",
                             e.name, a[18:3], a[2], a[1], a[0], e.v[18:3], e.v[2], e.v[1], e.v[0]);
                end
            end
        end
    endtask

    initial begin
        clear = 1'b1;
        idle_in();
        test_reset();
        test_entry();
        test_countdown();
        test_borrow();
        test_interlock();
        test_rejects();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_timer_countdown
`default_nettype wire
